xor_pipe_acc: RTL and testbench
===============================

Name: xor_pipe_acc

Overview:
- Parametrised, pipelined successor to the 2-input XOR gate cell.
- Computes bitwise a^b over WIDTH-bit operands, with optional running XOR accumulation and a reduced parity bit.
- Elastic valid/ready streaming with DEPTH register stages.
- Serves as a sequential benchmark block for gate-finding and rewrite experiments: XOR structure, registers and a handshake in one netlist.

Parameters:
- WIDTH, 8: operand and result width in bits (≥1).
- DEPTH, 2: number of pipeline register stages (≥1); sets latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- acc_en  in  1  sampled with the beat; 1 = fold the beat into the accumulator.
- acc_clr  in  1  sampled with the beat (or alone); clears the accumulator.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- c  out  WIDTH  result word.
- parity  out  1  XOR reduction of c, aligned with c.

Behaviour:
- Reset: clk and rst_n as above; polarity and synchronicity are fixed.
  - rst_n low asynchronously clears all stage valids, stage data, the accumulator acc, c and parity.
  - out_valid=0 during reset; in_ready=1 once rst_n is high.
  - A reset mid-stream discards all in-flight beats and the accumulator, with no partial output.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Stage-0 value for an accepted beat:
  - r = a ^ b.
  - If acc_en=0: result = r; acc unchanged, unless acc_clr=1, which sets acc=0.
  - If acc_en=1: result = r ^ acc_eff, where acc_eff = 0 if acc_clr=1, else acc. acc <= result.
- acc_clr without an accepted beat: acc <= 0 at the edge.
  - acc_clr while in_valid=1 but in_ready=0 also clears acc.
  - That beat later computes with acc_eff=0 only if acc_clr is still 1 when it is accepted.
- Accumulator semantics: acc updates at acceptance, not at output. Back-to-back accumulated beats are seen with 1-cycle throughput and no hazard.
- Pipeline:
  - DEPTH stages s0..s(DEPTH-1), each holding {valid, data[WIDTH]}.
  - Stage k is "free" if !valid_k, or if stage k+1 is free. The last stage is free if !out_valid or out_ready.
  - in_ready = free(s0), computed combinationally. The ready chain has no extra bubble, giving full throughput of 1 beat/cycle.
  - A stage loads from its predecessor when free. It clears valid when free and the predecessor is invalid.
- Output:
  - c and out_valid come from the last stage. parity = ^c is registered in the same stage as c; it is not a combinational tail.
  - Latency: accept at edge n gives out_valid at edge n+DEPTH-1, visible after that edge. The first result is valid DEPTH cycles after acceptance, counting the accepting edge as 1.
  - While out_valid && !out_ready, c, parity and out_valid hold stable. Upstream stages fill, then in_ready drops. No beat is dropped or duplicated.
- Ordering: strictly in order.
- Widths: all XOR is bitwise WIDTH-bit with no carries. parity is 1 bit.
- Simultaneous events:
  - Accept and output on the same edge with the pipe full and out_ready=1: both occur and occupancy is unchanged.
  - acc_clr and acc_en on the same beat: clear first, then fold, so the result equals r.

Test Plan (WIDTH=8, DEPTH=2):
- Reset, then one beat a=8'hF0, b=8'h3C, acc_en=0, out_ready=1 -> two edges later c=8'hCC, parity=0, out_valid high for exactly 1 cycle.
- Stream a=8'h01,8'h02,8'h04 with b=0, acc_en=1, acc_clr=1 on the first beat only -> c sequence 8'h01, 8'h03, 8'h07; parity sequence 1, 0, 1.
- Hold out_ready=0 while driving 4 valid beats -> exactly 2 accepted and in_ready=0 after. c is held stable at the first result. Release out_ready -> all beats emerge in order with none lost.
- Continuous stream of 16 beats with out_ready=1 -> 16 outputs in 16 consecutive cycles after the 2-cycle fill. Each c equals a^b of its beat.
- Accumulate acc to 8'hAA, then assert acc_clr alone for a cycle, then send a=8'h0F, b=0, acc_en=1 -> c=8'h0F.
- Assert rst_n low asynchronously with 2 beats in flight and acc=8'h55 -> out_valid drops immediately, c=0. After release, the first accumulated beat a=8'h11 gives c=8'h11.

Source files
------------

// File: rtl/xor_pipe_acc.sv
// Pipelined bitwise XOR with optional running XOR accumulation and registered parity.
// Elastic valid/ready stream through DEPTH register stages, strictly in order.
module xor_pipe_acc #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             parity
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] dat_q [DEPTH];
   logic             par_q;
   logic [WIDTH-1:0] acc_q;

   logic [DEPTH-1:0] free;
   logic [DEPTH-1:0] pred_v;
   logic [WIDTH-1:0] pred_d [DEPTH];
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] result;
   logic             accept;

   // Unrolled ready chain: stage k is free when out_ready is high or any stage k..DEPTH-1 is empty.
   always_comb begin
      free = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         free[k] = out_ready || (((~vld_q) >> k) != '0);
      end
   end

   assign in_ready = free[0];
   assign accept   = in_valid && free[0];

   // Clear takes effect before the fold, so a clr+en beat yields plain a^b.
   assign acc_eff = acc_clr ? '0 : acc_q;
   assign result  = acc_en ? (a ^ b ^ acc_eff) : (a ^ b);

   always_comb begin
      pred_v    = '0;
      pred_v[0] = in_valid;
      pred_d[0] = result;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         pred_v[k] = vld_q[k-1];
         pred_d[k] = dat_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (free[k]) begin
               vld_q[k] <= pred_v[k];
               if (pred_v[k]) begin
                  dat_q[k] <= pred_d[k];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (free[DEPTH-1] && pred_v[DEPTH-1]) begin
         par_q <= ^pred_d[DEPTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (accept && acc_en) begin
         acc_q <= result;
      end else if (acc_clr) begin
         acc_q <= '0;
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign c         = dat_q[DEPTH-1];
   assign parity    = par_q;

endmodule

// File: tb/tb_xor_pipe_acc.sv
// Directed self-checking bench for xor_pipe_acc at WIDTH=8, DEPTH=2.
module tb_xor_pipe_acc;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       acc_en;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] c;
   logic       parity;

   int unsigned pass_cnt;
   int unsigned chk_cnt;

   xor_pipe_acc #(.WIDTH(8), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .parity    (parity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                        input logic en, input logic clr);
      in_valid = v;
      a        = da;
      b        = db;
      acc_en   = en;
      acc_clr  = clr;
   endtask

   task automatic test_reset();
      #12;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'h00) $display("FAIL rst_c: got %h want 00", c); else pass_cnt++;
      chk_cnt++; if (parity !== 1'b0) $display("FAIL rst_parity: got %b want 0", parity); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive(1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0);
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", in_ready); else pass_cnt++;
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", out_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'hCC) $display("FAIL single_c: got %h want cc", c); else pass_cnt++;
      chk_cnt++; if (parity !== 1'b0) $display("FAIL single_parity: got %b want 0", parity); else pass_cnt++;
      tick();
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_accumulate();
      logic [7:0] in_a  [3];
      logic [7:0] exp_c [3];
      logic       exp_p [3];
      in_a  = '{8'h01, 8'h02, 8'h04};
      exp_c = '{8'h01, 8'h03, 8'h07};
      exp_p = '{1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(1'b1, in_a[i], 8'h00, 1'b1, (i == 0));
         else       drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         tick();
         if (i >= 1 && i <= 3) begin
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL acc_valid[%0d]: got %b want 1", i-1, out_valid); else pass_cnt++;
            chk_cnt++; if (c !== exp_c[i-1]) $display("FAIL acc_c[%0d]: got %h want %h", i-1, c, exp_c[i-1]); else pass_cnt++;
            chk_cnt++; if (parity !== exp_p[i-1]) $display("FAIL acc_parity[%0d]: got %b want %b", i-1, parity, exp_p[i-1]); else pass_cnt++;
         end else if (i == 4) begin
            chk_cnt++; if (out_valid !== 1'b0) $display("FAIL acc_drain: got %b want 0", out_valid); else pass_cnt++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] vals [4];
      int         sent;
      int         got;
      logic       ifire;
      vals = '{8'h10, 8'h20, 8'h30, 8'h40};
      sent = 0;
      got  = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[sent], 8'h00, 1'b0, 1'b0);
         #1;
         ifire = in_ready;
         tick();
         if (ifire) sent++;
      end
      drive(1'b1, vals[sent], 8'h00, 1'b0, 1'b0);
      #1;
      chk_cnt++; if (sent !== 2) $display("FAIL bp_accepted: got %0d want 2", sent); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'h10) $display("FAIL bp_hold_c: got %h want 10", c); else pass_cnt++;
      chk_cnt++; if (parity !== 1'b1) $display("FAIL bp_hold_parity: got %b want 1", parity); else pass_cnt++;
      out_ready = 1'b1;
      for (int t = 0; t < 16 && got < 4; t++) begin
         if (sent < 4) drive(1'b1, vals[sent], 8'h00, 1'b0, 1'b0);
         else          drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         ifire = in_valid && in_ready;
         if (out_valid) begin
            chk_cnt++; if (c !== vals[got]) $display("FAIL bp_order[%0d]: got %h want %h", got, c, vals[got]); else pass_cnt++;
            got++;
         end
         tick();
         if (ifire) sent++;
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk_cnt++; if (got !== 4) $display("FAIL bp_count: got %0d want 4", got); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] sa [16];
      logic [7:0] sb [16];
      logic [7:0] se [16];
      for (int i = 0; i < 16; i++) begin
         sa[i] = 8'(i * 37 + 5);
         sb[i] = 8'(i * 11);
         se[i] = sa[i] ^ sb[i];
      end
      out_ready = 1'b1;
      for (int t = 0; t < 19; t++) begin
         if (t < 16) drive(1'b1, sa[t], sb[t], 1'b0, 1'b0);
         else        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         if (t < 16) begin
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, in_ready); else pass_cnt++;
         end
         if (t >= 2 && t < 18) begin
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", t-2, out_valid); else pass_cnt++;
            chk_cnt++; if (c !== se[t-2]) $display("FAIL b2b_c[%0d]: got %h want %h", t-2, c, se[t-2]); else pass_cnt++;
            chk_cnt++; if (parity !== ^se[t-2]) $display("FAIL b2b_parity[%0d]: got %b want %b", t-2, parity, ^se[t-2]); else pass_cnt++;
         end else if (t == 18) begin
            chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", out_valid); else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_acc_clear();
      logic       tv   [4];
      logic [7:0] ta   [4];
      logic       ten  [4];
      logic       tclr [4];
      logic [7:0] want [3];
      logic [7:0] seen [$];
      tv   = '{1'b1, 1'b1, 1'b0, 1'b1};
      ta   = '{8'hA0, 8'h0A, 8'h00, 8'h0F};
      ten  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tclr = '{1'b1, 1'b0, 1'b1, 1'b0};
      want = '{8'hA0, 8'hAA, 8'h0F};
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         if (t < 4) drive(tv[t], ta[t], 8'h00, ten[t], tclr[t]);
         else       drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         if (out_valid) seen.push_back(c);
         tick();
      end
      chk_cnt++; if (seen.size() !== 3) $display("FAIL clr_count: got %0d want 3", seen.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         if (i < seen.size()) begin
            chk_cnt++; if (seen[i] !== want[i]) $display("FAIL clr_c[%0d]: got %h want %h", i, seen[i], want[i]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      drive(1'b1, 8'h55, 8'h00, 1'b1, 1'b1);
      tick();
      drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'h55) $display("FAIL mid_pre_c: got %h want 55", c); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_pre_full: got %b want 0", in_ready); else pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'h00) $display("FAIL mid_rst_c: got %h want 00", c); else pass_cnt++;
      chk_cnt++; if (parity !== 1'b0) $display("FAIL mid_rst_parity: got %b want 0", parity); else pass_cnt++;
      tick();
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 8'h11, 8'h00, 1'b1, 1'b0);
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_post_ready: got %b want 1", in_ready); else pass_cnt++;
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale: got %b want 0", out_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_post_valid: got %b want 1", out_valid); else pass_cnt++;
      chk_cnt++; if (c !== 8'h11) $display("FAIL mid_post_c: got %h want 11", c); else pass_cnt++;
      chk_cnt++; if (parity !== 1'b0) $display("FAIL mid_post_parity: got %b want 0", parity); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      chk_cnt   = 0;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      test_reset();
      test_single();
      test_accumulate();
      test_backpressure();
      test_back_to_back();
      test_acc_clear();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
